// File: rtl/keyboard_scan_decoder_if.sv
// Byte-stream input and held-key outputs of the PS/2 scan-code decoder.
interface keyboard_scan_decoder_if;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic [7:0] keyboard_data;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_space;
  logic       key_changed;

  modport master (
    output ps2_key_data, ps2_key_pressed,
    input  keyboard_data, key_left, key_right, key_up, key_space, key_changed
  );

  modport slave (
    input  ps2_key_data, ps2_key_pressed,
    output keyboard_data, key_left, key_right, key_up, key_space, key_changed
  );
endinterface

// File: rtl/keyboard_scan_decoder.sv
// Turns the PS/2 scan-code byte stream into held-key flags and a single
// active-key code that stays stable while the key is held.
module keyboard_scan_decoder #(
  parameter int PREFIX_TIMEOUT = 2_500_000,
  parameter int TO_WIDTH       = 22,
  parameter bit ACCEPT_KEYPAD  = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  keyboard_scan_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(PREFIX_TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] TO_MAX  = '1;

  state_t              state;
  state_t              state_nxt;
  logic [TO_WIDTH-1:0] to_cnt;
  logic [3:0]          held;
  logic [3:0]          held_nxt;
  logic [7:0]          kd;
  logic [7:0]          kd_nxt;
  logic                chg;
  logic                do_make;
  logic                do_break;
  logic                is_ext;
  logic [3:0]          hit;

  // Held-bit order: 0 Left, 1 Right, 2 Up, 3 Space.
  function automatic logic [3:0] key_of(input logic [7:0] code, input logic ext);
    logic [3:0] k;
    k = '0;
    case (code)
      8'h6B:   k[0] = ext | ACCEPT_KEYPAD;
      8'h74:   k[1] = ext | ACCEPT_KEYPAD;
      8'h75:   k[2] = ext | ACCEPT_KEYPAD;
      8'h29:   k[3] = ~ext;
      default: k = '0;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] code_of(input logic [3:0] k);
    if (k[0])      return 8'h6B;
    else if (k[1]) return 8'h74;
    else if (k[2]) return 8'h75;
    else if (k[3]) return 8'h29;
    else           return 8'h00;
  endfunction

  function automatic logic [7:0] fallback(input logic [3:0] h);
    if (h[1])      return 8'h74;
    else if (h[0]) return 8'h6B;
    else if (h[2]) return 8'h75;
    else if (h[3]) return 8'h29;
    else           return 8'h00;
  endfunction

  function automatic logic ignored(input logic [7:0] code);
    return code inside {8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      to_cnt <= '0;
      held   <= '0;
      kd     <= '0;
      chg    <= 1'b0;
    end else begin
      state <= state_nxt;
      held  <= held_nxt;
      kd    <= kd_nxt;
      chg   <= (kd_nxt != kd);
      if (bus.ps2_key_pressed)
        to_cnt <= '0;
      else if (state != IDLE && to_cnt != TO_MAX)
        to_cnt <= to_cnt + TO_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    do_make   = 1'b0;
    do_break  = 1'b0;
    is_ext    = 1'b0;
    if (bus.ps2_key_pressed) begin
      case (state)
        IDLE: begin
          if (bus.ps2_key_data == 8'hE0)      state_nxt = EXT;
          else if (bus.ps2_key_data == 8'hF0) state_nxt = BRK;
          else                                do_make = ~ignored(bus.ps2_key_data);
        end
        EXT: begin
          if (bus.ps2_key_data == 8'hF0)      state_nxt = EXT_BRK;
          else if (bus.ps2_key_data != 8'hE0) begin
            do_make   = 1'b1;
            is_ext    = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          if (bus.ps2_key_data == 8'hE0) state_nxt = EXT_BRK;
          else begin
            do_break  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          do_break  = 1'b1;
          is_ext    = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      // Abandon a dangling prefix; held keys are left alone.
      state_nxt = IDLE;
    end

    hit      = key_of(bus.ps2_key_data, is_ext);
    held_nxt = held;
    kd_nxt   = kd;
    if (do_make && hit != '0) begin
      held_nxt = held | hit;
      kd_nxt   = code_of(hit);
    end
    if (do_break && hit != '0) begin
      held_nxt = held & ~hit;
      if (kd == code_of(hit)) kd_nxt = fallback(held & ~hit);
    end
  end

  assign bus.keyboard_data = kd;
  assign bus.key_left      = held[0];
  assign bus.key_right     = held[1];
  assign bus.key_up        = held[2];
  assign bus.key_space     = held[3];
  assign bus.key_changed   = chg;

endmodule

// File: tb/tb_keyboard_scan_decoder.sv
// Bench for keyboard_scan_decoder: two instances (keypad accepted / rejected)
// share one byte stream and are checked every cycle against a behavioural model.
module tb_keyboard_scan_decoder;
  localparam int PT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  keyboard_scan_decoder_if kif_a ();
  keyboard_scan_decoder_if kif_b ();

  keyboard_scan_decoder #(.PREFIX_TIMEOUT(PT), .TO_WIDTH(4), .ACCEPT_KEYPAD(1'b1)) u_a (
    .clock(clock), .reset(reset), .bus(kif_a.slave));
  keyboard_scan_decoder #(.PREFIX_TIMEOUT(PT), .TO_WIDTH(4), .ACCEPT_KEYPAD(1'b0)) u_b (
    .clock(clock), .reset(reset), .bus(kif_b.slave));

  int vectors = 0;
  int miscompares = 0;
  int t = 0;

  // Model: pending prefix flags plus time of last byte; a prefix is still
  // live if the next byte arrives no more than PT cycles after it.
  localparam logic [7:0] CODES [4] = '{8'h6B, 8'h74, 8'h75, 8'h29};
  localparam int         PRIO  [4] = '{1, 0, 2, 3};
  bit         m_held [2][4];
  logic [7:0] m_kd   [2];
  bit         m_chg  [2];
  bit         m_ext  [2];
  bit         m_brk  [2];
  int         last_t [2];

  function automatic int key_idx(logic [7:0] b, bit ext, bit keypad);
    case (b)
      8'h6B:   return (ext || keypad) ? 0 : -1;
      8'h74:   return (ext || keypad) ? 1 : -1;
      8'h75:   return (ext || keypad) ? 2 : -1;
      8'h29:   return ext ? -1 : 3;
      default: return -1;
    endcase
  endfunction

  task automatic apply_key(int d, bit brk, logic [7:0] b, bit ext);
    int k;
    k = key_idx(b, ext, d == 0);
    if (k < 0) return;
    if (!brk) begin
      m_held[d][k] = 1;
      m_kd[d] = CODES[k];
    end else begin
      m_held[d][k] = 0;
      if (m_kd[d] == CODES[k]) begin
        m_kd[d] = 8'h00;
        for (int i = 3; i >= 0; i--)
          if (m_held[d][PRIO[i]]) m_kd[d] = CODES[PRIO[i]];
      end
    end
  endtask

  task automatic model_step(int d, bit rst, bit stb, logic [7:0] b);
    logic [7:0] old;
    bit pend, e, k;
    old = m_kd[d];
    if (rst) begin
      for (int i = 0; i < 4; i++) m_held[d][i] = 0;
      m_kd[d] = 8'h00; m_chg[d] = 0; m_ext[d] = 0; m_brk[d] = 0;
      return;
    end
    if (stb) begin
      pend = (m_ext[d] || m_brk[d]) && (t - last_t[d] <= PT);
      e = pend && m_ext[d];
      k = pend && m_brk[d];
      last_t[d] = t;
      if (e && k) begin
        apply_key(d, 1, b, 1); e = 0; k = 0;
      end else if (b == 8'hE0) begin
        e = 1;
      end else if (b == 8'hF0 && !k) begin
        k = 1;
      end else begin
        if (k) apply_key(d, 1, b, e);
        else if (e || !(b inside {8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) apply_key(d, 0, b, e);
        e = 0; k = 0;
      end
      m_ext[d] = e; m_brk[d] = k;
    end
    m_chg[d] = (m_kd[d] != old);
  endtask

  function automatic logic [12:0] dut_out(int d);
    if (d == 0)
      return {kif_a.keyboard_data, kif_a.key_left, kif_a.key_right, kif_a.key_up,
              kif_a.key_space, kif_a.key_changed};
    return {kif_b.keyboard_data, kif_b.key_left, kif_b.key_right, kif_b.key_up,
            kif_b.key_space, kif_b.key_changed};
  endfunction

  function automatic logic [12:0] model_out(int d);
    return {m_kd[d], m_held[d][0], m_held[d][1], m_held[d][2], m_held[d][3], m_chg[d]};
  endfunction

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (dut_out(d) !== model_out(d)) begin
        miscompares++;
        $display("FAIL outputs dut%0d t=%0d got={kd,l,r,u,s,chg}=%h want=%h",
                 d, t, dut_out(d), model_out(d));
      end
    end
  endtask

  task automatic check_kd(string name, int d, logic [7:0] lit);
    logic [7:0] got;
    got = dut_out(d) >> 5;
    vectors++;
    if (got !== lit || m_kd[d] !== lit) begin
      miscompares++;
      $display("FAIL %s dut%0d keyboard_data got=%h model=%h want=%h", name, d, got, m_kd[d], lit);
    end
  endtask

  task automatic check_bit(string name, logic got, logic lit);
    vectors++;
    if (got !== lit) begin
      miscompares++;
      $display("FAIL %s got=%b want=%b", name, got, lit);
    end
  endtask

  task automatic step(bit rst, bit stb, logic [7:0] b);
    logic [7:0] data;
    data = stb ? b : 8'($urandom);
    reset = rst;
    kif_a.ps2_key_pressed = stb; kif_a.ps2_key_data = data;
    kif_b.ps2_key_pressed = stb; kif_b.ps2_key_data = data;
    @(posedge clock);
    t++;
    model_step(0, rst, stb, b);
    model_step(1, rst, stb, b);
    @(negedge clock);
    compare_all();
  endtask

  task automatic send(logic [7:0] b);
    step(0, 1, b);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 8'h00);
  endtask

  localparam logic [7:0] POOL [14] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h29, 8'hE0,
                                        8'hF0, 8'h12, 8'h59, 8'h1C, 8'hFA, 8'hAA, 8'h00};

  initial begin
    kif_a.ps2_key_pressed = 0; kif_a.ps2_key_data = 0;
    kif_b.ps2_key_pressed = 0; kif_b.ps2_key_data = 0;
    @(negedge clock);

    // Reset wins over a coincident prefix strobe.
    step(1, 1, 8'hE0); step(1, 1, 8'hE0);
    check_kd("reset", 0, 8'h00);
    send(8'h6B);
    check_kd("idle_after_reset", 0, 8'h6B);
    check_kd("keypad_off", 1, 8'h00);

    step(1, 0, 8'h00);
    send(8'hE0); send(8'h6B);
    check_kd("left_make", 0, 8'h6B);
    check_bit("left_changed", kif_a.key_changed, 1'b1);
    repeat (3) begin send(8'hE0); send(8'h6B); end
    check_bit("typematic_no_pulse", kif_a.key_changed, 1'b0);
    send(8'hE0); send(8'h74);
    check_kd("right_make", 1, 8'h74);
    send(8'hE0); send(8'hF0); send(8'h74);
    check_kd("right_break", 1, 8'h6B);
    check_bit("right_cleared", kif_b.key_right, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_kd("left_break", 0, 8'h00);

    send(8'h29); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_kd("space_fallback", 1, 8'h29);
    send(8'h6B);
    check_kd("keypad_left_on", 0, 8'h6B);
    check_kd("keypad_left_off", 1, 8'h29);

    step(1, 0, 8'h00);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h6B);
    check_kd("fake_shift", 1, 8'h6B);
    send(8'hF0); send(8'h1C);
    check_kd("untracked_break", 1, 8'h6B);

    step(1, 0, 8'h00);
    send(8'hE0); idle(PT); send(8'h6B);
    check_kd("timeout_keypad_on", 0, 8'h6B);
    check_kd("timeout_keypad_off", 1, 8'h00);
    step(1, 0, 8'h00);
    send(8'hE0); idle(PT - 1); send(8'h6B);
    check_kd("prefix_last_cycle", 1, 8'h6B);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) step(1, $urandom_range(0, 1), POOL[$urandom_range(0, 13)]);
      else if ($urandom_range(0, 19) == 0) idle($urandom_range(PT - 2, PT + 2));
      else step(0, $urandom_range(0, 2) != 0, POOL[$urandom_range(0, 13)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
